// File: rtl/anita4_trig_pkg.sv
// rtl/anita4_trig_pkg.sv - shared encodings and defaults for the ANITA4 single-polarity trigger path
package anita4_trig_pkg;

  localparam int TIMER_W       = 8;
  localparam int DEF_CLR_WIDTH = 2;
  localparam int DEF_HOLDOFF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/anita4_sat_scaler.sv
// rtl/anita4_sat_scaler.sv - saturating event counter with periodic latch and sticky saturation flag
module anita4_sat_scaler #(
  parameter int SCALER_WIDTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_inc,
  input  logic                    i_latch,
  output logic [SCALER_WIDTH-1:0] o_scaler,
  output logic                    o_valid,
  output logic                    o_sat
);

  localparam logic [SCALER_WIDTH-1:0] ONES = '1;
  localparam logic [SCALER_WIDTH-1:0] ONE  = SCALER_WIDTH'(1);

  logic [SCALER_WIDTH-1:0] r_count;
  logic                    r_sat_flag;
  logic [SCALER_WIDTH-1:0] r_scaler;
  logic                    r_valid;
  logic                    r_sat;
  logic                    w_at_max;

  assign w_at_max = (r_count == ONES);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count    <= '0;
      r_sat_flag <= 1'b0;
      r_scaler   <= '0;
      r_valid    <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_valid <= i_latch;
      if (i_latch) begin
        // An event coinciding with the latch strobe belongs to the new period.
        r_scaler   <= r_count;
        r_sat      <= r_sat_flag;
        r_count    <= i_inc ? ONE : '0;
        r_sat_flag <= i_inc & (ONES == ONE);
      end else if (i_inc) begin
        if (!w_at_max) begin
          r_count <= r_count + ONE;
        end
        if (w_at_max || (r_count == ONES - ONE)) begin
          r_sat_flag <= 1'b1;
        end
      end
    end
  end

  assign o_scaler = r_scaler;
  assign o_valid  = r_valid;
  assign o_sat    = r_sat;

endmodule

// File: rtl/anita4_single_trig_rearm.sv
// rtl/anita4_single_trig_rearm.sv - per-channel trigger qualify, latch clear and holdoff re-arm controller
module anita4_single_trig_rearm
  import anita4_trig_pkg::*;
#(
  parameter int CLR_WIDTH    = DEF_CLR_WIDTH,
  parameter int HOLDOFF      = DEF_HOLDOFF,
  parameter int SCALER_WIDTH = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2:0]              TRIG_SYNC,
  input  logic                    MASK,
  input  logic                    SCALER_LATCH,
  output logic                    CLR,
  output logic                    TRIG_OUT,
  output logic                    BUSY,
  output logic [SCALER_WIDTH-1:0] SCALER,
  output logic                    SCALER_VALID,
  output logic                    SCALER_SAT
);

  localparam logic [TIMER_W-1:0] CLR_LOAD  = TIMER_W'(CLR_WIDTH - 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  state_t             r_state;
  logic [TIMER_W-1:0] r_timer;
  logic               r_clr;
  logic               r_trig;
  logic               w_detect;
  logic               w_count;
  logic               w_unused_sync;

  // Only the stable synchronizer tap qualifies an event.
  assign w_detect      = (r_state == ST_IDLE) & TRIG_SYNC[1];
  assign w_count       = w_detect & ~MASK;
  assign w_unused_sync = TRIG_SYNC[0] ^ TRIG_SYNC[2];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_clr   <= 1'b1;
      r_trig  <= 1'b0;
    end else begin
      r_trig <= w_count;
      case (r_state)
        ST_IDLE: begin
          if (TRIG_SYNC[1]) begin
            r_state <= ST_CLEAR;
            r_timer <= CLR_LOAD;
            r_clr   <= 1'b1;
          end else begin
            r_clr <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (r_timer == '0) begin
            r_clr <= 1'b0;
            if (HOLDOFF > 0) begin
              r_state <= ST_HOLD;
              r_timer <= HOLD_LOAD;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_timer == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_clr   <= 1'b0;
        end
      endcase
    end
  end

  anita4_sat_scaler #(
    .SCALER_WIDTH(SCALER_WIDTH)
  ) u_scaler (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_inc   (w_count),
    .i_latch (SCALER_LATCH),
    .o_scaler(SCALER),
    .o_valid (SCALER_VALID),
    .o_sat   (SCALER_SAT)
  );

  assign CLR      = r_clr;
  assign TRIG_OUT = r_trig;
  assign BUSY     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_anita4_single_trig_rearm.sv
// tb/tb_anita4_single_trig_rearm.sv - randomized self-checking bench with an event-level reference model
module tb_anita4_single_trig_rearm;

  localparam int CW  = 2;
  localparam int HO  = 4;
  localparam int SW  = 4;
  localparam int MAX = (1 << SW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [2:0]    TRIG_SYNC = 3'b000;
  logic          MASK = 1'b0;
  logic          SCALER_LATCH = 1'b0;
  logic          CLR;
  logic          TRIG_OUT;
  logic          BUSY;
  logic [SW-1:0] SCALER;
  logic          SCALER_VALID;
  logic          SCALER_SAT;

  int n_pass  = 0;
  int n_total = 0;

  int m_phase   = 0;
  bit m_rst_clr = 1'b1;
  bit m_trig    = 1'b0;
  int m_cnt     = 0;
  int m_scaler  = 0;
  bit m_valid   = 1'b0;
  bit m_sat     = 1'b0;

  anita4_single_trig_rearm #(
    .CLR_WIDTH   (CW),
    .HOLDOFF     (HO),
    .SCALER_WIDTH(SW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .TRIG_SYNC   (TRIG_SYNC),
    .MASK        (MASK),
    .SCALER_LATCH(SCALER_LATCH),
    .CLR         (CLR),
    .TRIG_OUT    (TRIG_OUT),
    .BUSY        (BUSY),
    .SCALER      (SCALER),
    .SCALER_VALID(SCALER_VALID),
    .SCALER_SAT  (SCALER_SAT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Phase counts cycles since an event was accepted: CLR is high for the first
  // CW of them, the channel is busy for CW+HO, and it re-arms afterwards.
  task automatic model_edge(input bit rst, input bit ts1, input bit mask, input bit latch);
    bit ev;
    if (rst) begin
      m_phase = 0; m_rst_clr = 1'b1; m_trig = 1'b0;
      m_cnt = 0; m_scaler = 0; m_valid = 1'b0; m_sat = 1'b0;
    end else begin
      ev        = (m_phase == 0) && ts1;
      m_rst_clr = 1'b0;
      m_trig    = ev && !mask;
      if (ev) m_phase = 1;
      else if (m_phase == CW + HO) m_phase = 0;
      else if (m_phase > 0) m_phase++;
      if (latch) begin
        m_scaler = (m_cnt > MAX) ? MAX : m_cnt;
        m_sat    = (m_cnt >= MAX);
        m_valid  = 1'b1;
        m_cnt    = m_trig ? 1 : 0;
      end else begin
        m_valid = 1'b0;
        m_cnt   = m_cnt + (m_trig ? 1 : 0);
      end
    end
  endtask

  task automatic step(input bit rst, input bit ts1, input bit mask, input bit latch);
    bit j0, j2;
    @(negedge CLK);
    j0 = 1'($urandom);
    j2 = 1'($urandom);
    RST = rst; TRIG_SYNC = {j2, ts1, j0}; MASK = mask; SCALER_LATCH = latch;
    @(posedge CLK);
    model_edge(rst, ts1, mask, latch);
    #1;
    chk("clr",    int'(CLR),          int'(m_rst_clr || (m_phase >= 1 && m_phase <= CW)));
    chk("trig",   int'(TRIG_OUT),     int'(m_trig));
    chk("busy",   int'(BUSY),         int'(m_phase != 0));
    chk("scaler", int'(SCALER),       m_scaler);
    chk("valid",  int'(SCALER_VALID), int'(m_valid));
    chk("sat",    int'(SCALER_SAT),   int'(m_sat));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic one_event(input bit mask, input bit latch);
    step(1'b0, 1'b1, mask, latch);
    for (int i = 0; i < CW + HO + 1; i++) step(1'b0, 1'b0, 1'($urandom), 1'b0);
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_clr", int'(CLR), 1);
    idle(1);
    chk("rel_clr", int'(CLR), 0);
    idle(8);

    one_event(1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("held_scaler", int'(SCALER), 10);
    chk("held_valid", int'(SCALER_VALID), 1);
    idle(1);
    chk("valid_one_cycle", int'(SCALER_VALID), 0);

    one_event(1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("masked_scaler", int'(SCALER), 0);

    for (int i = 0; i < 3; i++) one_event(1'b0, 1'b0);
    one_event(1'b0, 1'b1);
    chk("coincident_scaler", int'(SCALER), 3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("carry_scaler", int'(SCALER), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_scaler", int'(SCALER), 0);

    for (int i = 0; i < 20; i++) one_event(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sat_scaler", int'(SCALER), MAX);
    chk("sat_flag", int'(SCALER_SAT), 1);
    for (int i = 0; i < 2; i++) one_event(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_sat_scaler", int'(SCALER), 2);
    chk("post_sat_flag", int'(SCALER_SAT), 0);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort_clr", int'(CLR), 1);
    chk("abort_busy", int'(BUSY), 0);
    idle(2);

    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
           1'($urandom), ($urandom_range(0, 19) == 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/anita4_single_trig_rearm.md
Name: anita4_single_trig_rearm

Overview:
Per-channel re-arm controller that closes the loop with the single-polarity trigger latch and synchronizer. It watches the synchronized latch history (TRIG_SYNC), emits one qualified trigger pulse per latch event, and drives CLR back to the latch and synchronizer for a programmed width. It then enforces a holdoff, and counts unmasked singles into a periodically latched scaler. One instance sits beside each single-polarity channel in the ANITA4 trigger path.

Parameters:
CLR_WIDTH, 2, cycles CLR held high per event (legal 1..255)
HOLDOFF, 4, dead cycles after CLR drops before re-arming (legal 0..255)
SCALER_WIDTH, 16, scaler counter and output width

Ports:
CLK  input  1  system trigger clock; all logic on posedge
RST  input  1  synchronous active-high reset
TRIG_SYNC  input  3  synchronizer shift history; bit[1] is the qualified (stable) sample
MASK  input  1  1 = channel masked: still cleared, not reported or counted
SCALER_LATCH  input  1  one-cycle strobe ending a scaler period
CLR  output  1  clear to the latch flop and synchronizer (registered)
TRIG_OUT  output  1  one-cycle qualified trigger pulse (registered)
BUSY  output  1  1 whenever state != IDLE
SCALER  output  SCALER_WIDTH  count of unmasked events from the last completed period
SCALER_VALID  output  1  one-cycle pulse when SCALER updates
SCALER_SAT  output  1  last completed period saturated

Behaviour:
- Reset (RST=1 at posedge): state=IDLE, CLR=1 (keeps latch cleared during reset), TRIG_OUT=0, BUSY=0, SCALER=0, SCALER_VALID=0, SCALER_SAT=0, counter=0, timer=0. The first cycle after reset deasserts CLR.
- FSM states: IDLE, CLEAR, HOLD.
- IDLE: if TRIG_SYNC[1]=1 at edge N, then from N+1: state=CLEAR, CLR=1, timer=CLR_WIDTH-1, TRIG_OUT=~MASK (sampled at N) for exactly one cycle. TRIG_SYNC[0] and [2] are ignored.
- CLEAR: CLR stays 1. When timer=0, go to HOLD if HOLDOFF>0 (timer=HOLDOFF-1), else go to IDLE. CLR=0 on the cycle after leaving. Total CLR high time = CLR_WIDTH cycles exactly.
- HOLD: CLR=0. TRIG_SYNC is ignored. When timer=0, go to IDLE. Minimum event spacing = 1+CLR_WIDTH+HOLDOFF cycles.
- Re-arm: TRIG_SYNC[1] already high on the first IDLE cycle starts a new event immediately, with no lost cycle.
- MASK changing mid-event has no effect on the current event. Only the IDLE-detect-cycle value matters.
- Latency: TRIG_SYNC[1] rise to TRIG_OUT/CLR = 1 cycle.
- Scaler: the internal counter increments on each unmasked event (same cycle TRIG_OUT rises) and saturates at all-ones. A sticky sat flag is set when an increment is blocked or the counter hits all-ones.
- SCALER_LATCH at edge N: at N+1, SCALER=counter value including events counted through edge N-1 transitions, SCALER_SAT=sat flag, SCALER_VALID=1 for one cycle, counter=0, flag=0.
- Simultaneous: an event detected on the same edge as SCALER_LATCH is counted into the new period (counter=1 after the latch). Back-to-back SCALER_LATCH strobes produce SCALER=0 for the second.
- RST mid-event aborts immediately to reset values. The scaler period is discarded.

Decomposition:
- Shared package anita4_trig_pkg: FSM state encoding (IDLE=2'd0, CLEAR=2'd1, HOLD=2'd2), timer width constant (8), default CLR_WIDTH/HOLDOFF.
- One natural sub-module: anita4_sat_scaler (saturating counter + period latch + sat flag), parameterized by SCALER_WIDTH. The FSM/timer stays in the top.

Test Plan:
1. Reset release, TRIG_SYNC=000: CLR=1 during RST, 0 one cycle after. All other outputs 0, BUSY=0.
2. Single event, MASK=0, defaults: TRIG_SYNC[1] high at edge 10 -> TRIG_OUT=1 at cycle 11 only, CLR=1 cycles 11-12, BUSY=1 cycles 11-16, IDLE at 17.
3. TRIG_SYNC[1] held high continuously -> TRIG_OUT pulses every 7 cycles (1+2+4). Then SCALER_LATCH after 10 pulses -> SCALER=10, SCALER_VALID one cycle, SCALER_SAT=0.
4. MASK=1 event -> CLR sequence identical to scenario 2, TRIG_OUT stays 0, counter unchanged (latched SCALER=0). MASK toggling during CLEAR changes nothing.
5. Event on the same edge as SCALER_LATCH, with 3 prior events -> SCALER=3. The next SCALER_LATCH with no further events -> SCALER=1.
6. SCALER_WIDTH=4, 20 events in one period -> SCALER=15, SCALER_SAT=1. The next period with 2 events -> SCALER=2, SCALER_SAT=0. RST asserted during CLEAR -> CLR=1 (reset value), state IDLE, counter 0.
